set_assoc_cache_ctrl: RTL and testbench
=======================================

# set_assoc_cache_ctrl

Parametrised 2-way set-associative, write-through, no-write-allocate cache controller between the MEM stage and the SRAM controller. Generalises set count and tag width. Adds these features:
- explicit miss/write FSM holding SRAM requests until `sram_ready`
- invalid-way-first victim selection
- selectable write-hit policy (update or invalidate)
- saturating hit/miss counters

## Interface
Parameters:
- SET_BITS, 6, log2 of set count; index = address[SET_BITS+2:3]
- TAG_BITS, 9, tag = address[SET_BITS+TAG_BITS+2:SET_BITS+3]
- WRITE_UPDATE, 1, 1 = write hit updates the cached word; 0 = write hit clears that way's valid bit
- CNT_WIDTH, 16, hit/miss counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- address  in  32  byte address; bit 2 selects the word within a 64-bit line
- wdata  in  32  store data
- MEM_R_EN  in  1  load request
- MEM_W_EN  in  1  store request; wins over MEM_R_EN
- rdata  out  32  load data, valid while `ready`=1
- ready  out  1  access complete this cycle
- sram_address  out  32  = address
- sram_wdata  out  32  = wdata
- write  out  1  SRAM write request
- sram_mem_r_en  out  1  SRAM line-read request
- sram_rdata  in  64  line from SRAM
- sram_ready  in  1  SRAM completes current request this cycle
- hit_count  out  CNT_WIDTH  read hits, saturating
- miss_count  out  CNT_WIDTH  read misses, saturating

## Operation
- Storage per set, per way: valid bit, TAG_BITS tag, 64-bit data. One LRU bit per set, naming the way to replace next.
- hit_w = valid[w][index] && tag[w][index]==tag field; the two ways never both hit.
- FSM states: IDLE, RMISS, WTHRU.
- **IDLE transitions:**
  - MEM_W_EN=1 → WTHRU.
  - Else MEM_R_EN=1 and a hit: ready=1 with rdata = hit way word[address[2]]; stay in IDLE.
  - Else MEM_R_EN=1 and a miss → RMISS.
  - No request: stay; ready=0.
- **RMISS:**
  - sram_mem_r_en=1 every cycle until sram_ready.
  - On the sram_ready cycle: ready=1; rdata = sram_rdata[63:32] if address[2], else [31:0].
  - Same edge: fill the victim with sram_rdata, write its tag, set valid, then → IDLE.
- **Victim selection:** way 0 if invalid; else way 1 if invalid; else the way named by LRU.
- **WTHRU:**
  - write=1 until sram_ready; on that cycle ready=1 → IDLE.
  - Same edge, on a hit: WRITE_UPDATE=1 writes wdata into word[address[2]] of the hit way; WRITE_UPDATE=0 clears that way's valid bit.
  - Write miss: no allocation, cache unchanged.
- **LRU update:**
  - Read hit in way w → LRU = ~w.
  - Fill into way w → LRU = ~w.
  - Write hit with update in way w → LRU = ~w.
  - Nothing else changes LRU.
- **Counters:**
  - hit_count +1 per IDLE cycle with a read hit (MEM_R_EN=1, MEM_W_EN=0).
  - miss_count +1 per RMISS completion.
  - Both saturate at all-ones.
- Requester holds address, wdata and enables stable until ready. Input changes in RMISS/WTHRU are undefined, except rst.

## Timing
- **Reset** (rst=1 at an edge) returns FSM to IDLE from any state and aborts any in-flight request. It clears:
  - all valid bits
  - all LRU bits
  - both counters
- **Outputs while rst is high:** ready=0, write=0, sram_mem_r_en=0. rdata and data arrays are don't-care.
- **Combinational outputs:** ready, rdata, write and sram_mem_r_en are combinational from state and inputs. sram_address and sram_wdata are pass-through.
- **Read hit:** 0-cycle latency; ready in the same cycle as the request.
- **Read miss:**
  - Detected in cycle 0 (IDLE, ready=0).
  - sram_mem_r_en high from cycle 1.
  - ready in the sram_ready cycle, so minimum latency is 1 cycle after detection.
- **Write:** same shape as a read miss; write high from cycle 1; ready on the sram_ready cycle. A write is never completed from IDLE.
- sram_ready arriving while in IDLE is ignored.
- A back-to-back request may be presented in the cycle after ready; that is an IDLE cycle.
- A filled line hits on the very next read of it (next cycle).

## Test plan
- **Reset, then read miss:** rst 1 cycle; read 0x0000_0204, sram_ready after 3 RMISS cycles with sram_rdata=0x1111_2222_3333_4444.
  - ready on that cycle, rdata=0x1111_2222.
  - Re-read next cycle hits with ready the same cycle.
  - miss_count=1, hit_count=1.
- **Invalid-first and LRU eviction:** fill tags A, B at index 5.
  - A goes to way 0, B to way 1.
  - Read A (hit) → LRU=1.
  - Miss on tag C at index 5 replaces B.
  - Reads of A hit; a read of B misses.
- **Write hit, WRITE_UPDATE=1:** write 0xDEAD_BEEF to a cached address with bit 2=0.
  - write high until sram_ready.
  - The following read hits and returns 0xDEAD_BEEF.
- **Write hit, WRITE_UPDATE=0, then write miss:**
  - Write hit clears valid; the next read of the line misses.
  - Write to an uncached address leaves hit_count/miss_count and cache contents unchanged.
- **Reset mid-RMISS, and simultaneous enables:**
  - rst during RMISS drops sram_mem_r_en the next cycle; all reads afterwards miss.
  - MEM_R_EN=MEM_W_EN=1 → WTHRU, write=1, sram_mem_r_en=0.
- **Saturation (CNT_WIDTH=4):** 20 consecutive read-hit cycles → hit_count holds at 15.

Source files
------------

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative write-through, no-write-allocate cache controller.
// Ports: clk/rst, MEM-stage request (address, wdata, MEM_R_EN, MEM_W_EN) and
// completion (rdata, ready); SRAM side (sram_address, sram_wdata, write,
// sram_mem_r_en, sram_rdata, sram_ready); saturating hit_count/miss_count.
module set_assoc_cache_ctrl #(
  parameter int SET_BITS     = 6,
  parameter int TAG_BITS     = 9,
  parameter int WRITE_UPDATE = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          address,
  input  logic [31:0]          wdata,
  input  logic                 MEM_R_EN,
  input  logic                 MEM_W_EN,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic [31:0]          sram_address,
  output logic [31:0]          sram_wdata,
  output logic                 write,
  output logic                 sram_mem_r_en,
  input  logic [63:0]          sram_rdata,
  input  logic                 sram_ready,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int SETS = 1 << SET_BITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RMISS = 2'd1,
    WTHRU = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [SET_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;

  logic [SETS-1:0]     valid0;
  logic [SETS-1:0]     valid1;
  logic [SETS-1:0]     lru;
  logic [TAG_BITS-1:0] tag0  [SETS];
  logic [TAG_BITS-1:0] tag1  [SETS];
  logic [63:0]         data0 [SETS];
  logic [63:0]         data1 [SETS];

  logic        hit0;
  logic        hit1;
  logic        hit;
  logic [63:0] hit_line;
  logic [31:0] hit_word;
  logic [31:0] fill_word;
  logic        victim;

  logic fill;
  logic rd_hit;
  logic wr_done;

  assign idx = address[SET_BITS+2:3];
  assign tag = address[SET_BITS+TAG_BITS+2:SET_BITS+3];

  assign sram_address = address;
  assign sram_wdata   = wdata;

  assign hit0 = valid0[idx] && (tag0[idx] == tag);
  assign hit1 = valid1[idx] && (tag1[idx] == tag);
  assign hit  = hit0 || hit1;

  assign hit_line  = hit1 ? data1[idx] : data0[idx];
  assign hit_word  = address[2] ? hit_line[63:32]
                                : hit_line[31:0];
  assign fill_word = address[2] ? sram_rdata[63:32]
                                : sram_rdata[31:0];

  // Empty ways are always consumed before LRU eviction kicks in.
  assign victim = !valid0[idx] ? 1'b0 :
                  !valid1[idx] ? 1'b1 : lru[idx];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    ready         = 1'b0;
    rdata         = '0;
    write         = 1'b0;
    sram_mem_r_en = 1'b0;
    fill          = 1'b0;
    rd_hit        = 1'b0;
    wr_done       = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (MEM_W_EN) begin
            state_n = WTHRU;
          end else if (MEM_R_EN) begin
            if (hit) begin
              ready  = 1'b1;
              rdata  = hit_word;
              rd_hit = 1'b1;
            end else begin
              state_n = RMISS;
            end
          end
        end
        RMISS: begin
          sram_mem_r_en = 1'b1;
          if (sram_ready) begin
            ready   = 1'b1;
            rdata   = fill_word;
            fill    = 1'b1;
            state_n = IDLE;
          end
        end
        WTHRU: begin
          write = 1'b1;
          if (sram_ready) begin
            ready   = 1'b1;
            wr_done = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Valid and LRU state; LRU always points away from the way just used.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid0 <= '0;
      valid1 <= '0;
      lru    <= '0;
    end else begin
      if (rd_hit) lru[idx] <= hit0;
      if (fill) begin
        if (victim) valid1[idx] <= 1'b1;
        else        valid0[idx] <= 1'b1;
        lru[idx] <= ~victim;
      end
      if (wr_done && hit) begin
        if (WRITE_UPDATE != 0) begin
          lru[idx] <= hit0;
        end else begin
          if (hit0) valid0[idx] <= 1'b0;
          if (hit1) valid1[idx] <= 1'b0;
        end
      end
    end
  end

  // Tag and data arrays need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (fill) begin
      if (victim) begin
        tag1[idx]  <= tag;
        data1[idx] <= sram_rdata;
      end else begin
        tag0[idx]  <= tag;
        data0[idx] <= sram_rdata;
      end
    end
    if (wr_done && hit && (WRITE_UPDATE != 0)) begin
      if (hit0) begin
        if (address[2]) data0[idx][63:32] <= wdata;
        else            data0[idx][31:0]  <= wdata;
      end
      if (hit1) begin
        if (address[2]) data1[idx][63:32] <= wdata;
        else            data1[idx][31:0]  <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (rd_hit && (hit_count != '1))
        hit_count <= hit_count + 1'b1;
      if (fill && (miss_count != '1))
        miss_count <= miss_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Testbench for set_assoc_cache_ctrl: table-driven cycle vectors plus
// directed sequences on an update/4-bit-counter and an invalidate instance.
module tb_set_assoc_cache_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst           [2];
  logic [31:0] address       [2];
  logic [31:0] wdata         [2];
  logic        mem_r_en      [2];
  logic        mem_w_en      [2];
  logic [31:0] rdata         [2];
  logic        ready         [2];
  logic [31:0] sram_address  [2];
  logic [31:0] sram_wdata    [2];
  logic        write         [2];
  logic        sram_mem_r_en [2];
  logic [63:0] sram_rdata    [2];
  logic        sram_ready    [2];
  logic [3:0]  hc0;
  logic [3:0]  mc0;
  logic [15:0] hc1;
  logic [15:0] mc1;

  set_assoc_cache_ctrl #(
    .WRITE_UPDATE(1),
    .CNT_WIDTH(4)
  ) u0 (
    .clk(clk), .rst(rst[0]),
    .address(address[0]), .wdata(wdata[0]),
    .MEM_R_EN(mem_r_en[0]), .MEM_W_EN(mem_w_en[0]),
    .rdata(rdata[0]), .ready(ready[0]),
    .sram_address(sram_address[0]), .sram_wdata(sram_wdata[0]),
    .write(write[0]), .sram_mem_r_en(sram_mem_r_en[0]),
    .sram_rdata(sram_rdata[0]), .sram_ready(sram_ready[0]),
    .hit_count(hc0), .miss_count(mc0)
  );

  set_assoc_cache_ctrl #(
    .WRITE_UPDATE(0),
    .CNT_WIDTH(16)
  ) u1 (
    .clk(clk), .rst(rst[1]),
    .address(address[1]), .wdata(wdata[1]),
    .MEM_R_EN(mem_r_en[1]), .MEM_W_EN(mem_w_en[1]),
    .rdata(rdata[1]), .ready(ready[1]),
    .sram_address(sram_address[1]), .sram_wdata(sram_wdata[1]),
    .write(write[1]), .sram_mem_r_en(sram_mem_r_en[1]),
    .sram_rdata(sram_rdata[1]), .sram_ready(sram_ready[1]),
    .hit_count(hc1), .miss_count(mc1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  function automatic logic [31:0] ad(input int t, input int i);
    ad = (t << 9) | (i << 3);
  endfunction

  function automatic logic [31:0] wsel(input logic [63:0] l,
                                       input logic [31:0] a);
    wsel = a[2] ? l[63:32] : l[31:0];
  endfunction

  typedef struct {
    bit          rs;
    bit          r;
    bit          w;
    logic [31:0] a;
    logic [31:0] wd;
    bit          sr;
    logic [63:0] srd;
    bit          e_rdy;
    logic [31:0] e_rd;
    bit          c_rd;
    bit          e_wr;
    bit          e_ren;
    int          e_hc;
    int          e_mc;
  } vec_t;

  function automatic vec_t mk(
    bit rs, bit r, bit w, logic [31:0] a, logic [31:0] wd,
    bit sr, logic [63:0] srd, bit e_rdy, logic [31:0] e_rd,
    bit c_rd, bit e_wr, bit e_ren, int e_hc, int e_mc);
    mk = '{rs, r, w, a, wd, sr, srd, e_rdy, e_rd,
           c_rd, e_wr, e_ren, e_hc, e_mc};
  endfunction

  task automatic do_reset(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    mem_r_en[d] = 1'b0;
    mem_w_en[d] = 1'b0;
    sram_ready[d] = 1'b0;
    @(negedge clk);
    rst[d] = 1'b0;
  endtask

  // One complete access; hit reports ready in the request cycle.
  task automatic access(input int d, input bit w, input bit r,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [63:0] line, input int dly,
                        output bit hit, output logic [31:0] data);
    bit done;
    int k;
    @(negedge clk);
    mem_w_en[d] = w;
    mem_r_en[d] = r;
    address[d] = a;
    wdata[d] = wd;
    sram_rdata[d] = line;
    sram_ready[d] = 1'b0;
    #1;
    hit = ready[d];
    data = rdata[d];
    done = ready[d];
    chk("idle_write_low", {63'd0, write[d]}, 64'd0);
    if (w) chk("write_ready_idle", {63'd0, ready[d]}, 64'd0);
    k = 0;
    while (!done && k < dly + 10) begin
      @(negedge clk);
      sram_ready[d] = (k == dly);
      #1;
      chk("req_write", {63'd0, write[d]}, {63'd0, w});
      chk("req_rden", {63'd0, sram_mem_r_en[d]}, {63'd0, !w});
      chk("req_ready", {63'd0, ready[d]}, {63'd0, k == dly});
      if (ready[d]) begin
        done = 1'b1;
        data = rdata[d];
      end
      k++;
    end
    if (!done) chk("access_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    mem_r_en[d] = 1'b0;
    mem_w_en[d] = 1'b0;
    sram_ready[d] = 1'b0;
  endtask

  vec_t tv[$];

  localparam logic [63:0] L1 = 64'h1111_2222_3333_4444;

  initial begin
    bit h;
    logic [31:0] dt;
    logic [31:0] a_a;
    logic [31:0] a_b;
    logic [31:0] a_c;
    logic [31:0] a_x;
    logic [63:0] la;
    logic [63:0] lb;
    logic [63:0] lc;
    logic [63:0] la2;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      address[d] = '0;
      wdata[d] = '0;
      mem_r_en[d] = 1'b0;
      mem_w_en[d] = 1'b0;
      sram_rdata[d] = '0;
      sram_ready[d] = 1'b0;
    end

    // rs r w addr wdata sr srd | rdy rdata c_rd wr ren hc mc
    tv.push_back(mk(1,0,0,32'h204,0,0,0, 0,0,0, 0,0, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,0,0, 0,0,0, 0,0, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,0,0, 0,0,0, 0,1, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,0,0, 0,0,0, 0,1, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,0,0, 0,0,0, 0,1, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,1,L1,
                    1,32'h1111_2222,1, 0,1, 0,0));
    tv.push_back(mk(0,1,0,32'h204,0,0,0,
                    1,32'h1111_2222,1, 0,0, 0,1));
    tv.push_back(mk(0,0,0,32'h204,0,0,0, 0,0,0, 0,0, 1,1));
    tv.push_back(mk(0,0,1,32'h200,32'hDEAD_BEEF,0,0,
                    0,0,0, 0,0, 1,1));
    tv.push_back(mk(0,0,1,32'h200,32'hDEAD_BEEF,0,0,
                    0,0,0, 1,0, 1,1));
    tv.push_back(mk(0,0,1,32'h200,32'hDEAD_BEEF,1,0,
                    1,0,0, 1,0, 1,1));
    tv.push_back(mk(0,1,0,32'h200,0,0,0,
                    1,32'hDEAD_BEEF,1, 0,0, 1,1));
    tv.push_back(mk(0,1,0,32'h204,0,0,0,
                    1,32'h1111_2222,1, 0,0, 2,1));
    tv.push_back(mk(0,0,0,32'h204,0,1,0, 0,0,0, 0,0, 3,1));
    tv.push_back(mk(0,0,0,32'h204,0,0,0, 0,0,0, 0,0, 3,1));

    @(posedge clk);
    foreach (tv[i]) begin
      @(negedge clk);
      rst[0] = tv[i].rs;
      mem_r_en[0] = tv[i].r;
      mem_w_en[0] = tv[i].w;
      address[0] = tv[i].a;
      wdata[0] = tv[i].wd;
      sram_ready[0] = tv[i].sr;
      sram_rdata[0] = tv[i].srd;
      #1;
      chk($sformatf("v%0d_ready", i), {63'd0, ready[0]},
          {63'd0, tv[i].e_rdy});
      chk($sformatf("v%0d_write", i), {63'd0, write[0]},
          {63'd0, tv[i].e_wr});
      chk($sformatf("v%0d_rden", i), {63'd0, sram_mem_r_en[0]},
          {63'd0, tv[i].e_ren});
      chk($sformatf("v%0d_hits", i), {60'd0, hc0}, 64'(tv[i].e_hc));
      chk($sformatf("v%0d_miss", i), {60'd0, mc0}, 64'(tv[i].e_mc));
      if (tv[i].c_rd)
        chk($sformatf("v%0d_rdata", i), {32'd0, rdata[0]},
            {32'd0, tv[i].e_rd});
      chk($sformatf("v%0d_saddr", i), {32'd0, sram_address[0]},
          {32'd0, tv[i].a});
    end
    @(negedge clk);
    mem_r_en[0] = 1'b0;
    mem_w_en[0] = 1'b0;
    sram_ready[0] = 1'b0;

    a_a = ad(2, 5);
    a_b = ad(3, 5);
    a_c = ad(4, 5);
    la  = 64'hA0A0_0001_A0A0_0000;
    lb  = 64'hB0B0_0001_B0B0_0000;
    lc  = 64'hC0C0_0001_C0C0_0000;
    la2 = 64'hA2A2_0001_A2A2_0000;

    // LRU eviction on u0 at index 5.
    access(0, 0, 1, a_a, 0, la, 1, h, dt);
    chk("lru_a_miss", {63'd0, h}, 64'd0);
    chk("lru_a_fill_data", {32'd0, dt}, {32'd0, wsel(la, a_a)});
    access(0, 0, 1, a_b, 0, lb, 0, h, dt);
    chk("lru_b_miss", {63'd0, h}, 64'd0);
    access(0, 0, 1, a_a, 0, 0, 0, h, dt);
    chk("lru_a_hit", {63'd0, h}, 64'd1);
    chk("lru_a_hit_data", {32'd0, dt}, {32'd0, wsel(la, a_a)});
    access(0, 0, 1, a_c, 0, lc, 2, h, dt);
    chk("lru_c_miss", {63'd0, h}, 64'd0);
    access(0, 0, 1, a_a | 32'h4, 0, 0, 0, h, dt);
    chk("lru_a_kept", {63'd0, h}, 64'd1);
    chk("lru_a_hi_data", {32'd0, dt}, {32'd0, la[63:32]});
    access(0, 0, 1, a_c, 0, 0, 0, h, dt);
    chk("lru_c_hit", {63'd0, h}, 64'd1);
    access(0, 0, 1, a_b, 0, lb, 0, h, dt);
    chk("lru_b_evicted", {63'd0, h}, 64'd0);

    // Reset in the middle of a read miss on u0.
    @(negedge clk);
    address[0] = ad(7, 7);
    mem_r_en[0] = 1'b1;
    #1;
    chk("abort_idle_ready", {63'd0, ready[0]}, 64'd0);
    @(negedge clk);
    #1;
    chk("abort_rmiss_rden", {63'd0, sram_mem_r_en[0]}, 64'd1);
    @(negedge clk);
    rst[0] = 1'b1;
    #1;
    chk("abort_rst_rden", {63'd0, sram_mem_r_en[0]}, 64'd0);
    chk("abort_rst_ready", {63'd0, ready[0]}, 64'd0);
    @(negedge clk);
    rst[0] = 1'b0;
    mem_r_en[0] = 1'b0;
    #1;
    chk("abort_after_rden", {63'd0, sram_mem_r_en[0]}, 64'd0);
    chk("abort_hits_clr", {60'd0, hc0}, 64'd0);
    chk("abort_miss_clr", {60'd0, mc0}, 64'd0);
    access(0, 0, 1, a_a, 0, la, 0, h, dt);
    chk("post_rst_a_miss", {63'd0, h}, 64'd0);
    access(0, 0, 1, 32'h204, 0, L1, 0, h, dt);
    chk("post_rst_204_miss", {63'd0, h}, 64'd0);

    // Counter saturation on u0 (4-bit).
    @(negedge clk);
    address[0] = 32'h204;
    mem_r_en[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      #1;
      chk($sformatf("sat_ready%0d", i), {63'd0, ready[0]}, 64'd1);
      if (i == 14) chk("sat_hits14", {60'd0, hc0}, 64'd14);
      @(negedge clk);
    end
    mem_r_en[0] = 1'b0;
    #1;
    chk("sat_hits", {60'd0, hc0}, 64'd15);
    chk("sat_miss", {60'd0, mc0}, 64'd2);

    // Simultaneous enables take the write path.
    access(0, 1, 1, ad(4, 5), 32'h5555_AAAA, 0, 1, h, dt);
    chk("both_en_hits", {60'd0, hc0}, 64'd15);

    // Invalidate-on-write-hit instance.
    do_reset(1);
    access(1, 0, 1, a_a, 0, la, 0, h, dt);
    chk("u1_a_miss", {63'd0, h}, 64'd0);
    access(1, 0, 1, a_b, 0, lb, 2, h, dt);
    chk("u1_b_miss", {63'd0, h}, 64'd0);
    chk("u1_b_fill_data", {32'd0, dt}, {32'd0, lb[31:0]});
    access(1, 0, 1, a_b | 32'h4, 0, 0, 0, h, dt);
    chk("u1_b_hit", {63'd0, h}, 64'd1);
    chk("u1_b_hi_data", {32'd0, dt}, {32'd0, lb[63:32]});
    access(1, 0, 1, a_a, 0, 0, 0, h, dt);
    chk("u1_a_hit", {63'd0, h}, 64'd1);
    access(1, 1, 0, a_a, 32'h1234_5678, 0, 1, h, dt);
    access(1, 0, 1, a_c, 0, lc, 0, h, dt);
    chk("u1_c_miss", {63'd0, h}, 64'd0);
    access(1, 0, 1, a_b, 0, 0, 0, h, dt);
    chk("u1_b_kept_invalid_first", {63'd0, h}, 64'd1);
    access(1, 0, 1, a_a, 0, la2, 1, h, dt);
    chk("u1_a_invalidated", {63'd0, h}, 64'd0);
    chk("u1_a_refill_data", {32'd0, dt}, {32'd0, la2[31:0]});
    chk("u1_hits_pre", hc1, 64'd3);
    chk("u1_miss_pre", mc1, 64'd4);
    a_x = ad(9, 12);
    access(1, 1, 0, a_x, 32'hCAFE_F00D, 0, 3, h, dt);
    chk("u1_wmiss_hits", hc1, 64'd3);
    chk("u1_wmiss_miss", mc1, 64'd4);
    access(1, 0, 1, a_b, 0, 0, 0, h, dt);
    chk("u1_b_still_hit", {63'd0, h}, 64'd1);
    chk("u1_b_still_data", {32'd0, dt}, {32'd0, lb[31:0]});
    access(1, 0, 1, a_x, 0, 64'h9, 0, h, dt);
    chk("u1_no_allocate", {63'd0, h}, 64'd0);
    chk("u1_hits_end", hc1, 64'd4);
    chk("u1_miss_end", mc1, 64'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
